// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: control codes, FSM state encoding
// and the helper that screens out unsupported control codes.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic ctrl_valid(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR)  || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit ALU slice: AND/OR/ripple-add on optionally inverted
// operands, exposing the carry into its MSB so the caller can form overflow.
module alu_digit_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_a_inv,
    input  logic             i_b_inv,
    input  logic             i_cin,
    input  logic [1:0]       i_op,
    output logic [DIGIT-1:0] o_result,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic w_c;
    logic w_ai;
    logic w_bi;

    always_comb begin
        o_result = '0;
        o_cmsb   = 1'b0;
        w_c      = i_cin;
        w_ai     = 1'b0;
        w_bi     = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            w_ai = i_a[i] ^ i_a_inv;
            w_bi = i_b[i] ^ i_b_inv;
            if (i == DIGIT - 1) o_cmsb = w_c;
            case (i_op)
                2'd0:    o_result[i] = w_ai & w_bi;
                2'd1:    o_result[i] = w_ai | w_bi;
                default: o_result[i] = w_ai ^ w_bi ^ w_c;
            endcase
            w_c = (w_ai & w_bi) | (w_c & (w_ai | w_bi));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits per cycle LSB first behind a
// start/busy/done handshake; results and flags only change in the DONE cycle.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_shift;

    logic [DIGIT-1:0] w_res;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_final;
    logic             w_valid;
    logic             w_arith;
    logic             w_ovf;

    alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .i_a      (r_a[DIGIT-1:0]),
        .i_b      (r_b[DIGIT-1:0]),
        .i_a_inv  (r_ctrl[3]),
        .i_b_inv  (r_ctrl[2]),
        .i_cin    (r_carry),
        .i_op     (r_ctrl[1:0]),
        .o_result (w_res),
        .o_cout   (w_cout),
        .o_cmsb   (w_cmsb)
    );

    assign w_last = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // New digits enter at the MSB end so the LSB digit lands at bit 0 after NDIG steps.
    assign w_shift_next = (r_shift >> DIGIT) | (WIDTH'(w_res) << (WIDTH - DIGIT));
    assign w_valid      = ctrl_valid(r_ctrl);
    assign w_arith      = w_valid & r_ctrl[1];
    assign w_ovf        = w_cmsb ^ w_cout;

    always_comb begin
        w_final = w_shift_next;
        if (!w_valid)                w_final = '0;
        else if (r_ctrl == ALU_SLT)  w_final = WIDTH'(w_res[DIGIT-1] ^ w_ovf);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= '0;
            r_shift    <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= ctrl_i[2];
            r_a     <= src1_i;
            r_b     <= src2_i;
            r_ctrl  <= ctrl_i;
            r_shift <= '0;
        end else if (w_step) begin
            r_cnt   <= r_cnt + 1'b1;
            r_carry <= w_cout;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_shift <= w_shift_next;
            if (w_last) begin
                result_o   <= w_final;
                zero_o     <= (w_final == '0);
                cout_o     <= w_arith & w_cout;
                overflow_o <= w_arith & w_ovf;
            end
        end
    end

    assign busy_o = (r_state == RUN);
    assign done_o = (r_state == DONE);

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial at DIGIT=4, plus DIGIT=1 and
// DIGIT=32 instances for the latency extremes.
module tb_alu_serial;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src1, src2;
    logic [3:0]  ctrl;
    logic        start_m, start_1, start_32;

    logic        busy_m, done_m, zero_m, cout_m, ovf_m;
    logic [31:0] res_m;
    logic        busy_1, done_1, zero_1, cout_1, ovf_1;
    logic [31:0] res_1;
    logic        busy_32, done_32, zero_32, cout_32, ovf_32;
    logic [31:0] res_32;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_m), .src1_i(src1), .src2_i(src2),
        .ctrl_i(ctrl), .busy_o(busy_m), .done_o(done_m), .result_o(res_m),
        .zero_o(zero_m), .cout_o(cout_m), .overflow_o(ovf_m));

    alu_serial #(.WIDTH(32), .DIGIT(1)) u_dut_d1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_1), .src1_i(src1), .src2_i(src2),
        .ctrl_i(ctrl), .busy_o(busy_1), .done_o(done_1), .result_o(res_1),
        .zero_o(zero_1), .cout_o(cout_1), .overflow_o(ovf_1));

    alu_serial #(.WIDTH(32), .DIGIT(32)) u_dut_d32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_32), .src1_i(src1), .src2_i(src2),
        .ctrl_i(ctrl), .busy_o(busy_32), .done_o(done_32), .result_o(res_32),
        .zero_o(zero_32), .cout_o(cout_32), .overflow_o(ovf_32));

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done_m : (sel == 1) ? done_1 : done_32;
    endfunction

    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? busy_m : (sel == 1) ? busy_1 : busy_32;
    endfunction

    // Drives one operation; lat = cycles from the start cycle to the done cycle, -1 on timeout.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, output int lat, output int nbusy);
        @(negedge clk);
        src1 = a; src2 = b; ctrl = c;
        start_m = (sel == 0); start_1 = (sel == 1); start_32 = (sel == 2);
        lat = -1;
        nbusy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin start_m = 1'b0; start_1 = 1'b0; start_32 = 1'b0; end
            if (sel_busy(sel)) nbusy++;
            if (sel_done(sel)) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_m); end
        n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done_m); end
        n_cmp++; if (res_m !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b exp 000", {zero_m, cout_m, ovf_m}); end
    endtask

    task automatic test_add();
        int lat, nb;
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, lat, nb);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL add_latency got %0d exp 9", lat); end
        n_cmp++; if (nb !== 8) begin n_err++; $display("FAIL add_busy_cycles got %0d exp 8", nb); end
        n_cmp++; if (res_m !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h exp 80000000", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b001) begin
            n_err++; $display("FAIL add_flags zco got %b exp 001", {zero_m, cout_m, ovf_m}); end
        @(posedge clk); #1;
        n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL add_done_one_cycle got %b exp 0", done_m); end
        n_cmp++; if (res_m !== 32'h8000_0000) begin n_err++; $display("FAIL add_result_hold got %h exp 80000000", res_m); end
    endtask

    task automatic test_sub();
        int lat, nb;
        do_op(0, 32'h0000_0005, 32'h0000_0005, ALU_SUB, lat, nb);
        n_cmp++; if (res_m !== 32'h0) begin n_err++; $display("FAIL sub_eq_result got %h exp 0", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b110) begin
            n_err++; $display("FAIL sub_eq_flags zco got %b exp 110", {zero_m, cout_m, ovf_m}); end
        do_op(0, 32'h8000_0000, 32'h0000_0001, ALU_SUB, lat, nb);
        n_cmp++; if (res_m !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_ovf_result got %h exp 7fffffff", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b011) begin
            n_err++; $display("FAIL sub_ovf_flags zco got %b exp 011", {zero_m, cout_m, ovf_m}); end
    endtask

    task automatic test_slt();
        int lat, nb;
        do_op(0, 32'hFFFF_FFFD, 32'h0000_0002, ALU_SLT, lat, nb);
        n_cmp++; if (res_m !== 32'h1) begin n_err++; $display("FAIL slt_neg_result got %h exp 1", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b010) begin
            n_err++; $display("FAIL slt_neg_flags zco got %b exp 010", {zero_m, cout_m, ovf_m}); end
        do_op(0, 32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, lat, nb);
        n_cmp++; if (res_m !== 32'h0) begin n_err++; $display("FAIL slt_ovf_result got %h exp 0", res_m); end
        n_cmp++; if ({zero_m, cout_m, ovf_m} !== 3'b101) begin
            n_err++; $display("FAIL slt_ovf_flags zco got %b exp 101", {zero_m, cout_m, ovf_m}); end
    endtask

    task automatic test_logic();
        logic [3:0]  codes [4] = '{ALU_AND, ALU_OR, ALU_NOR, 4'b0011};
        logic [31:0] exps  [4] = '{32'h000F_000F, 32'h0FFF_0FFF, 32'hF000_F000, 32'h0000_0000};
        int lat, nb;
        for (int i = 0; i < 4; i++) begin
            do_op(0, 32'h0F0F_0F0F, 32'h00FF_00FF, codes[i], lat, nb);
            n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL logic_latency ctrl=%b got %0d exp 9", codes[i], lat); end
            n_cmp++; if (res_m !== exps[i]) begin
                n_err++; $display("FAIL logic_result ctrl=%b got %h exp %h", codes[i], res_m, exps[i]); end
            n_cmp++; if ({zero_m, cout_m, ovf_m} !== {(exps[i] == 32'h0), 2'b00}) begin
                n_err++; $display("FAIL logic_flags ctrl=%b got %b exp %b", codes[i],
                                  {zero_m, cout_m, ovf_m}, {(exps[i] == 32'h0), 2'b00}); end
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_done;
        logic [31:0] exp_res;
        ctrl = ALU_ADD;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start_m = (c < 27);
            if (c == 0)       begin src1 = 32'd1;  src2 = 32'd1;  end
            else if (c == 9)  begin src1 = 32'd10; src2 = 32'd20; end
            else if (c == 18) begin src1 = 32'd7;  src2 = 32'd8;  end
            else              begin src1 = 32'h111 * c; src2 = 32'h5555; end
            @(posedge clk); #1;
            exp_done = (c + 1 == 9) || (c + 1 == 18) || (c + 1 == 27);
            exp_res  = (c + 1 == 9) ? 32'd2 : (c + 1 == 18) ? 32'd30 : 32'd15;
            n_cmp++; if (done_m !== exp_done) begin
                n_err++; $display("FAIL b2b_done cycle=%0d got %b exp %b", c + 1, done_m, exp_done); end
            if (exp_done) begin
                n_cmp++; if (res_m !== exp_res) begin
                    n_err++; $display("FAIL b2b_result cycle=%0d got %h exp %h", c + 1, res_m, exp_res); end
            end
        end
        start_m = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, ndone;
        @(negedge clk);
        src1 = 32'h1234_5678; src2 = 32'h1111_1111; ctrl = ALU_ADD; start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        n_cmp++; if (busy_m !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got %b exp 1", busy_m); end
        rst_n = 1'b0; #1;
        n_cmp++; if (res_m !== 32'h0) begin n_err++; $display("FAIL rst_async_result got %h exp 0", res_m); end
        n_cmp++; if ({busy_m, done_m, zero_m, cout_m, ovf_m} !== 5'b0) begin
            n_err++; $display("FAIL rst_async_status got %b exp 00000", {busy_m, done_m, zero_m, cout_m, ovf_m}); end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done_m || busy_m) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL rst_abort_no_done got %0d exp 0", ndone); end
        do_op(0, 32'd2, 32'd3, ALU_ADD, lat, nb);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL rst_add_latency got %0d exp 9", lat); end
        n_cmp++; if (res_m !== 32'd5) begin n_err++; $display("FAIL rst_add_result got %h exp 5", res_m); end
    endtask

    task automatic test_digit_variants();
        int lat, nb;
        do_op(1, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, lat, nb);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL d1_latency got %0d exp 33", lat); end
        n_cmp++; if (res_1 !== 32'h8000_0000) begin n_err++; $display("FAIL d1_result got %h exp 80000000", res_1); end
        n_cmp++; if ({zero_1, cout_1, ovf_1} !== 3'b001) begin
            n_err++; $display("FAIL d1_flags zco got %b exp 001", {zero_1, cout_1, ovf_1}); end
        do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, lat, nb);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL d32_latency got %0d exp 2", lat); end
        n_cmp++; if (res_32 !== 32'h8000_0000) begin n_err++; $display("FAIL d32_result got %h exp 80000000", res_32); end
        n_cmp++; if ({zero_32, cout_32, ovf_32} !== 3'b001) begin
            n_err++; $display("FAIL d32_flags zco got %b exp 001", {zero_32, cout_32, ovf_32}); end
        do_op(2, 32'h0000_0005, 32'h0000_0005, ALU_SUB, lat, nb);
        n_cmp++; if ({res_32, zero_32, cout_32, ovf_32} !== {32'h0, 3'b110}) begin
            n_err++; $display("FAIL d32_sub got %h/%b exp 0/110", res_32, {zero_32, cout_32, ovf_32}); end
    endtask

    initial begin
        rst_n = 1'b0;
        start_m = 1'b0; start_1 = 1'b0; start_32 = 1'b0;
        src1 = '0; src2 = '0; ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_variants();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
